// File: rtl/cuckoo_pkg.sv
// Shared types and constants for the cuckoo clock: sequencer state encoding,
// servo duty endpoints and the strike-count clamp.
package cuckoo_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StOpen,
    StHold,
    StClose,
    StGap,
    StDone
  } state_e;

  localparam int unsigned DutyClosed = 15;
  localparam int unsigned DutyOpen   = 75;
  localparam int unsigned MaxStrikes = 12;

  function automatic logic [3:0] clamp_strikes(input logic [3:0] cnt, input logic [3:0] max_cnt);
    return (cnt > max_cnt) ? max_cnt : cnt;
  endfunction

endpackage

// File: rtl/cuckoo_servo_sequencer_if.sv
// Control/status bundle between the clock/alarm logic (master) and the
// servo sequencer (slave).
interface cuckoo_servo_sequencer_if;
  logic       start;
  logic [3:0] strike_cnt;
  logic       abort;
  logic [6:0] duty;
  logic       busy;
  logic       done;
  logic [3:0] strike_idx;

  modport master (
    output start, strike_cnt, abort,
    input  duty, busy, done, strike_idx
  );

  modport slave (
    input  start, strike_cnt, abort,
    output duty, busy, done, strike_idx
  );
endinterface

// File: rtl/step_tick_gen.sv
// Ramp prescaler: pulses tick every STEP_CYC cycles; clear holds the count at 0
// so the first tick lands STEP_CYC edges after clear drops.
module step_tick_gen #(
  parameter int unsigned STEP_CYC = 1_000_000
) (
  input  logic clk,
  input  logic reset_p,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STEP_CYC - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == CntLast);

  always_ff @(posedge clk) begin
    if (reset_p || clear) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/cuckoo_servo_sequencer.sv
// Cuckoo-door servo sequencer: per strike ramps duty closed->open, holds,
// ramps back, then pauses; abort closes the door from wherever it is.
module cuckoo_servo_sequencer
  import cuckoo_pkg::*;
#(
  parameter int unsigned STEP_CYC    = 1_000_000,
  parameter int unsigned DUTY_CLOSED = DutyClosed,
  parameter int unsigned DUTY_OPEN   = DutyOpen,
  parameter int unsigned HOLD_STEPS  = 50,
  parameter int unsigned GAP_STEPS   = 30,
  parameter int unsigned MAX_STRIKES = MaxStrikes
) (
  input logic                     clk,
  input logic                     reset_p,
  cuckoo_servo_sequencer_if.slave bus
);

  localparam logic [6:0] DutyClosedW = 7'(DUTY_CLOSED);
  localparam logic [6:0] DutyOpenW   = 7'(DUTY_OPEN);
  // At or below this, one more decrement reaches (or would pass) closed.
  localparam logic [6:0] DutyLastDn  = 7'(DUTY_CLOSED + 1);
  localparam logic [3:0] MaxStrikesW = 4'(MAX_STRIKES);

  localparam int unsigned StepMax = (HOLD_STEPS > GAP_STEPS) ? HOLD_STEPS : GAP_STEPS;
  localparam int unsigned StepW   = $clog2(StepMax + 1);
  localparam logic [StepW-1:0] HoldLast = StepW'(HOLD_STEPS - 1);
  localparam logic [StepW-1:0] GapLast  = StepW'(GAP_STEPS - 1);

  state_e           state_q;
  logic [6:0]       duty_q;
  logic             done_q;
  logic [3:0]       idx_q;
  logic [3:0]       n_q;
  logic [StepW-1:0] step_q;
  logic             abort_q;
  logic             tick;

  step_tick_gen #(
    .STEP_CYC(STEP_CYC)
  ) u_step_tick_gen (
    .clk    (clk),
    .reset_p(reset_p),
    .clear  (state_q == StIdle),
    .tick   (tick)
  );

  assign bus.duty       = duty_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = done_q;
  assign bus.strike_idx = idx_q;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q <= StIdle;
      duty_q  <= DutyClosedW;
      done_q  <= 1'b0;
      idx_q   <= '0;
      n_q     <= '0;
      step_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          abort_q <= 1'b0;
          idx_q   <= '0;
          duty_q  <= DutyClosedW;
          if (bus.start) begin
            if (bus.strike_cnt == 4'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              n_q     <= clamp_strikes(bus.strike_cnt, MaxStrikesW);
              idx_q   <= 4'd1;
              state_q <= StOpen;
            end
          end
        end
        StOpen: begin
          if (tick && duty_q != DutyOpenW) begin
            duty_q <= duty_q + 7'd1;
          end
          if (bus.abort) begin
            abort_q <= 1'b1;
            state_q <= StClose;
          end else if (tick && (duty_q + 7'd1) == DutyOpenW) begin
            state_q <= StHold;
            step_q  <= '0;
          end
        end
        StHold: begin
          if (bus.abort) begin
            abort_q <= 1'b1;
            state_q <= StClose;
          end else if (tick) begin
            if (step_q == HoldLast) begin
              state_q <= StClose;
            end else begin
              step_q <= step_q + StepW'(1);
            end
          end
        end
        StClose: begin
          if (bus.abort) begin
            abort_q <= 1'b1;
          end
          if (tick) begin
            if (duty_q <= DutyLastDn) begin
              duty_q <= DutyClosedW;
              if (abort_q || bus.abort || idx_q == n_q) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                state_q <= StGap;
                step_q  <= '0;
              end
            end else begin
              duty_q <= duty_q - 7'd1;
            end
          end
        end
        StGap: begin
          if (bus.abort) begin
            abort_q <= 1'b1;
            state_q <= StClose;
          end else if (tick) begin
            if (step_q == GapLast) begin
              idx_q   <= idx_q + 4'd1;
              state_q <= StOpen;
            end else begin
              step_q <= step_q + StepW'(1);
            end
          end
        end
        StDone: begin
          if (bus.abort) begin
            abort_q <= 1'b1;
          end
          idx_q   <= '0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cuckoo_servo_sequencer.sv
// Directed bench for cuckoo_servo_sequencer with a small step period; scenario
// and checkpoint tables hold hand-computed outputs after numbered edges.
module tb_cuckoo_servo_sequencer;

  logic clk = 1'b0;
  logic reset_p;
  int   checks = 0;
  int   errors = 0;

  cuckoo_servo_sequencer_if bus ();

  cuckoo_servo_sequencer #(
    .STEP_CYC   (4),
    .DUTY_CLOSED(15),
    .DUTY_OPEN  (18),
    .HOLD_STEPS (2),
    .GAP_STEPS  (1),
    .MAX_STRIKES(12)
  ) dut (
    .clk    (clk),
    .reset_p(reset_p),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // One sequence: start sampled at edge 0; optional abort/second start/reset
  // sampled at the given edge (-1 = never); run through last_e.
  typedef struct {
    logic [3:0] cnt;
    int         abort_e;
    int         start2_e;
    int         reset_e;
    int         last_e;
  } scn_t;

  // Expected outputs just after edge edge_n of scenario scn.
  typedef struct {
    int         scn;
    int         edge_n;
    logic [6:0] duty;
    logic       busy;
    logic       done;
    logic [3:0] idx;
  } chk_t;

  scn_t scns[10];
  chk_t chks[$];

  task automatic check_out(input string nm, input logic [6:0] d, input logic b,
                           input logic dn, input logic [3:0] ix);
    checks++;
    if (bus.duty !== d || bus.busy !== b || bus.done !== dn || bus.strike_idx !== ix) begin
      errors++;
      $display("FAIL %s: got duty=%0d busy=%0b done=%0b idx=%0d, want duty=%0d busy=%0b done=%0b idx=%0d",
               nm, bus.duty, bus.busy, bus.done, bus.strike_idx, d, b, dn, ix);
    end
  endtask

  task automatic add(input int s, input int e, input int d, input logic b, input logic dn,
                     input int ix);
    chks.push_back(chk_t'{s, e, 7'(d), b, dn, 4'(ix)});
  endtask

  initial begin
    //               cnt    abort start2 reset last
    scns[0] = '{4'd1,  -1, -1, -1,  40};  // single strike
    scns[1] = '{4'd2,  -1, -1, -1,  72};  // two strikes
    scns[2] = '{4'd3,  15, -1, -1,  40};  // abort in HOLD
    scns[3] = '{4'd0,  -1, -1, -1,   8};  // zero strikes
    scns[4] = '{4'd15, -1, -1, -1, 432};  // clamp to 12
    scns[5] = '{4'd1,  -1, 10, -1,  36};  // start while busy
    scns[6] = '{4'd1,  -1, -1,  7,  12};  // reset mid-ramp
    scns[7] = '{4'd1,   0, -1, -1,  34};  // start+abort together in IDLE
    scns[8] = '{4'd2,  34, -1, -1,  40};  // abort in GAP
    scns[9] = '{4'd1,   6, -1, -1,  12};  // abort in OPEN

    add(0, 0, 15, 1, 0, 1);  add(0, 3, 15, 1, 0, 1);  add(0, 4, 16, 1, 0, 1);
    add(0, 8, 17, 1, 0, 1);  add(0, 12, 18, 1, 0, 1); add(0, 20, 18, 1, 0, 1);
    add(0, 23, 18, 1, 0, 1); add(0, 24, 17, 1, 0, 1); add(0, 28, 16, 1, 0, 1);
    add(0, 31, 16, 1, 0, 1); add(0, 32, 15, 1, 1, 1); add(0, 33, 15, 0, 0, 0);
    add(0, 40, 15, 0, 0, 0);

    add(1, 32, 15, 1, 0, 1); add(1, 35, 15, 1, 0, 1); add(1, 36, 15, 1, 0, 2);
    add(1, 40, 16, 1, 0, 2); add(1, 48, 18, 1, 0, 2); add(1, 56, 18, 1, 0, 2);
    add(1, 60, 17, 1, 0, 2); add(1, 67, 16, 1, 0, 2); add(1, 68, 15, 1, 1, 2);
    add(1, 69, 15, 0, 0, 0);

    add(2, 14, 18, 1, 0, 1); add(2, 15, 18, 1, 0, 1); add(2, 16, 17, 1, 0, 1);
    add(2, 20, 16, 1, 0, 1); add(2, 24, 15, 1, 1, 1); add(2, 25, 15, 0, 0, 0);
    add(2, 40, 15, 0, 0, 0);

    add(3, 0, 15, 1, 1, 0);  add(3, 1, 15, 0, 0, 0);  add(3, 8, 15, 0, 0, 0);

    add(4, 36, 15, 1, 0, 2);   add(4, 395, 15, 1, 0, 11); add(4, 396, 15, 1, 0, 12);
    add(4, 400, 16, 1, 0, 12); add(4, 428, 15, 1, 1, 12); add(4, 429, 15, 0, 0, 0);

    add(5, 12, 18, 1, 0, 1); add(5, 24, 17, 1, 0, 1); add(5, 32, 15, 1, 1, 1);
    add(5, 33, 15, 0, 0, 0); add(5, 36, 15, 0, 0, 0);

    add(6, 4, 16, 1, 0, 1);  add(6, 6, 16, 1, 0, 1);  add(6, 7, 15, 0, 0, 0);
    add(6, 12, 15, 0, 0, 0);

    add(7, 12, 18, 1, 0, 1); add(7, 20, 18, 1, 0, 1); add(7, 32, 15, 1, 1, 1);
    add(7, 33, 15, 0, 0, 0);

    add(8, 32, 15, 1, 0, 1); add(8, 34, 15, 1, 0, 1); add(8, 35, 15, 1, 0, 1);
    add(8, 36, 15, 1, 1, 1); add(8, 37, 15, 0, 0, 0); add(8, 40, 15, 0, 0, 0);

    add(9, 4, 16, 1, 0, 1);  add(9, 6, 16, 1, 0, 1);  add(9, 8, 15, 1, 1, 1);
    add(9, 9, 15, 0, 0, 0);

    // Reset held for three cycles.
    reset_p        = 1'b1;
    bus.start      = 1'b0;
    bus.strike_cnt = 4'd0;
    bus.abort      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset_state", 7'd15, 1'b0, 1'b0, 4'd0);
    reset_p = 1'b0;
    @(posedge clk);
    #1;
    check_out("post_reset_idle", 7'd15, 1'b0, 1'b0, 4'd0);

    // Start is not accepted while reset is asserted.
    reset_p        = 1'b1;
    bus.start      = 1'b1;
    bus.strike_cnt = 4'd1;
    @(posedge clk);
    #1;
    reset_p   = 1'b0;
    bus.start = 1'b0;
    check_out("start_under_reset", 7'd15, 1'b0, 1'b0, 4'd0);

    // Abort alone in IDLE does nothing.
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check_out("abort_in_idle", 7'd15, 1'b0, 1'b0, 4'd0);

    for (int s = 0; s < 10; s++) begin
      repeat (3) @(posedge clk);
      #1;
      for (int e = 0; e <= scns[s].last_e; e++) begin
        bus.start      = (e == 0) || (e == scns[s].start2_e);
        bus.strike_cnt = (e == 0) ? scns[s].cnt : 4'd5;
        bus.abort      = (e == scns[s].abort_e);
        reset_p        = (e == scns[s].reset_e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        reset_p   = 1'b0;
        checks++;
        if (bus.duty < 7'd15 || bus.duty > 7'd18) begin
          errors++;
          $display("FAIL duty_range s%0d_e%0d: got duty=%0d, want 15..18", s, e, bus.duty);
        end
        foreach (chks[k]) begin
          if (chks[k].scn == s && chks[k].edge_n == e) begin
            check_out($sformatf("s%0d_e%0d", s, e), chks[k].duty, chks[k].busy,
                      chks[k].done, chks[k].idx);
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cuckoo_servo_sequencer.md
Name: cuckoo_servo_sequencer

Overview:
- Sequences the cuckoo-door servo on the hour strike.
- For each strike it ramps the servo duty from closed to open, holds, ramps back to closed, then pauses before the next strike.
- Drives the 7-bit duty input of the existing pwm_Nstep_freq instance configured with duty_step=600 and pwm_freq=50.
- Sits between the clock/alarm logic (which issues start and the hour count) and the servo PWM.

Parameters:
- STEP_CYC, 1_000_000, clk cycles per ramp step tick (10 ms at 100 MHz).
- DUTY_CLOSED, 15, duty value for door closed; also the reset/idle value.
- DUTY_OPEN, 75, duty value for door open; must be greater than DUTY_CLOSED and at most 127.
- HOLD_STEPS, 50, ticks spent fully open per strike.
- GAP_STEPS, 30, ticks spent closed between consecutive strikes.
- MAX_STRIKES, 12, clamp for strike_cnt.

Ports:
- clk  in  1  system clock.
- reset_p  in  1  synchronous active-high reset.
- start  in  1  single-cycle request to begin a strike sequence.
- strike_cnt  in  4  number of strikes; sampled only when start is accepted.
- abort  in  1  request to close the door and end the sequence.
- duty  out  7  servo duty to pwm_Nstep_freq.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when a sequence ends, whether completed or aborted.
- strike_idx  out  4  current strike number, 1..N while busy; 0 in IDLE.

Behaviour:
- Clock and reset: one clock, clk. reset_p is synchronous and active-high.
- Reset values:
  - duty=DUTY_CLOSED, busy=0, done=0, strike_idx=0.
  - FSM=IDLE, prescaler=0, step counter=0, abort latch=0.
  - Reset mid-sequence snaps duty to DUTY_CLOSED at that edge; there is no ramp.
- Step tick:
  - Prescaler counts 0..STEP_CYC-1 and tick=1 when count==STEP_CYC-1.
  - Prescaler is held at 0 in IDLE and cleared on the edge that accepts start, so the first tick is processed STEP_CYC edges after acceptance.
- FSM states: IDLE, OPEN, HOLD, CLOSE, GAP, DONE.
- IDLE:
  - start=1 with strike_cnt==0: go to DONE directly; no motion.
  - start=1 with strike_cnt>0: latch N=min(strike_cnt, MAX_STRIKES), set strike_idx=1, go to OPEN.
  - abort in IDLE is ignored. If start and abort are both high in IDLE, start is accepted and abort is ignored.
- OPEN: on each tick duty+1. On the edge where duty becomes DUTY_OPEN, go to HOLD and clear the step counter.
- HOLD: count ticks; after HOLD_STEPS ticks go to CLOSE.
- CLOSE: on each tick duty-1. On the edge where duty becomes DUTY_CLOSED:
  - go to DONE if abort is latched or strike_idx==N;
  - otherwise go to GAP and clear the step counter.
- GAP: after GAP_STEPS ticks, strike_idx+1 and go to OPEN.
- DONE: done=1 for exactly this cycle, then go to IDLE. strike_idx returns to 0 on entering IDLE.
- Abort:
  - abort=1 in OPEN, HOLD or GAP sets the abort latch and forces CLOSE on the next edge, with the ramp continuing from the current duty.
  - abort in CLOSE or DONE only sets the latch.
  - Abort in GAP (duty already closed) goes to CLOSE, which exits to DONE on the next tick without decrementing below DUTY_CLOSED.
  - The latch is cleared in IDLE.
- start while busy is ignored; it is not queued.
- duty invariant: duty always stays within [DUTY_CLOSED, DUTY_OPEN]; no wrap-around. A tick and a state change on the same edge apply the state's tick action first.

Decomposition:
- Shared package cuckoo_pkg holds:
  - FSM state encoding (IDLE, OPEN, HOLD, CLOSE, GAP, DONE);
  - servo duty constants (DUTY_CLOSED=15, DUTY_OPEN=75) and MAX_STRIKES=12, also used by the clock top and the FND display.
- One sub-module: step_tick_gen (parameter STEP_CYC; inputs clk, reset_p, clear; output tick). It is the prescaler.
- The FSM, ramp and counters live in the top.

Test Plan (STEP_CYC=4, DUTY_CLOSED=15, DUTY_OPEN=18, HOLD_STEPS=2, GAP_STEPS=1, start sampled at edge e0):
- Reset check: hold reset_p for 3 cycles, then release -> duty=15, busy=0, done=0, strike_idx=0.
- Single strike with strike_cnt=1:
  - duty 16/17/18 at e4/e8/e12;
  - HOLD through e20;
  - duty 17/16/15 at e24/e28/e32;
  - done=1 only in the cycle after e32;
  - busy falls after the done cycle.
- Two strikes with strike_cnt=2:
  - strike_idx=1 until GAP ends at e36;
  - strike_idx=2 and second OPEN follow;
  - done=1 in the cycle after e68;
  - duty never exceeds 18 or drops below 15.
- Abort in HOLD: abort pulse at e14 -> CLOSE at e15; duty 17/16/15 at e16/e20/e24; done after e24; no second strike even with strike_cnt=3.
- Zero strikes and clamp:
  - strike_cnt=0 -> done pulse the cycle after e0, duty stays 15;
  - strike_cnt=15 -> strike_idx reaches 12 and the sequence ends.
- Ignored inputs and reset mid-ramp:
  - start pulse while busy -> no effect on timing;
  - reset_p at e6 during OPEN -> duty=15, FSM=IDLE at e7.
